pc_next_unit: RTL and testbench

- Program-counter register and next-PC selector for the MIPS fetch stage.
- Consumes the word-aligned branch offset from the shift-left-by-2 stage (offset already shifted, bits[1:0]=0) and the J-type index.
- Holds the PC across stalls and instruction-memory wait states.
- Buffers one redirect that arrives while fetch cannot advance, and applies it when fetch next advances.

---
 rtl/pc_next_unit.sv | 101 ++++++++++
 tb/tb_pc_next_unit.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/pc_next_unit.sv
// Fetch-stage program counter: next-PC selection, stall/wait hold, one-deep
// redirect buffer and a sticky misalignment flag.
module pc_next_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        imem_ready,
  input  logic        branch_taken,
  input  logic [31:0] branch_base,
  input  logic [31:0] branch_offset,
  input  logic        jump_en,
  input  logic [31:0] jump_base,
  input  logic [25:0] jump_index,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        fetch_valid,
  output logic        redirect_pending,
  output logic        misalign
);

  localparam int unsigned W    = 32;
  localparam int unsigned WORD = W - 2;
  localparam logic [W-1:0] RESET_PC_ALIGNED = {RESET_PC[W-1:2], 2'b00};

  typedef enum logic {BOOT, RUN} state_t;

  state_t          state, state_next;
  logic [W-1:0]    pending_target, pending_target_next;
  logic [W-1:0]    pc_next;
  logic            pending_next, misalign_next;
  logic            advance, redirect, misalign_hit;
  logic [WORD-1:0] branch_word;
  logic [W-1:0]    branch_target, jump_target, target;
  logic            unused_jump_bits;

  // Region bits come from jump_base; only its low bits matter for the error check.
  assign unused_jump_bits = ^jump_base[27:2];

  // Offset is pre-shifted, so summing word addresses drops the low bits for free.
  assign branch_word   = WORD'(branch_base[W-1:2] + branch_offset[W-1:2]);
  assign branch_target = {branch_word, 2'b00};
  assign jump_target   = {jump_base[31:28], jump_index, 2'b00};
  assign target        = jump_en ? jump_target : branch_target;
  assign redirect      = jump_en | branch_taken;
  assign advance       = (state == RUN) & imem_ready & ~stall;
  assign pc_plus4      = W'(pc + W'(4));

  assign misalign_hit = (branch_taken & ((branch_offset[1:0] != 2'b00) |
                                         (branch_base[1:0]   != 2'b00))) |
                        (jump_en & (jump_base[1:0] != 2'b00));

  // Next-state and next-PC selection; a buffered redirect outranks a new one.
  always_comb begin
    state_next          = state;
    pc_next             = pc;
    pending_next        = redirect_pending;
    pending_target_next = pending_target;
    misalign_next       = misalign | misalign_hit;

    case (state)
      BOOT:    state_next = RUN;
      RUN:     state_next = RUN;
      default: state_next = BOOT;
    endcase

    if (advance) begin
      if (redirect_pending) begin
        pc_next      = pending_target;
        pending_next = 1'b0;
      end else if (redirect) begin
        pc_next = target;
      end else begin
        pc_next = pc_plus4;
      end
    end else if (redirect && !redirect_pending) begin
      pending_next        = 1'b1;
      pending_target_next = target;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= BOOT;
      pc               <= RESET_PC_ALIGNED;
      fetch_valid      <= 1'b0;
      redirect_pending <= 1'b0;
      pending_target   <= '0;
      misalign         <= 1'b0;
    end else begin
      state            <= state_next;
      pc               <= pc_next;
      fetch_valid      <= (state_next == RUN);
      redirect_pending <= pending_next;
      pending_target   <= pending_target_next;
      misalign         <= misalign_next;
    end
  end

endmodule

// File: tb/tb_pc_next_unit.sv
// Self-checking bench for pc_next_unit: directed scenarios followed by
// randomized traffic compared against a queue-based reference model.
module tb_pc_next_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall, imem_ready, branch_taken, jump_en;
  logic [31:0] branch_base, branch_offset, jump_base;
  logic [25:0] jump_index;
  logic [31:0] pc, pc_plus4;
  logic        fetch_valid, redirect_pending, misalign;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state
  logic [31:0] m_pc;
  logic [31:0] m_pend[$];
  bit          m_run;
  bit          m_mis;

  pc_next_unit dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .imem_ready(imem_ready),
    .branch_taken(branch_taken), .branch_base(branch_base),
    .branch_offset(branch_offset), .jump_en(jump_en), .jump_base(jump_base),
    .jump_index(jump_index), .pc(pc), .pc_plus4(pc_plus4),
    .fetch_valid(fetch_valid), .redirect_pending(redirect_pending),
    .misalign(misalign)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all();
    check("pc", pc, m_pc);
    check("pc_plus4", pc_plus4, m_pc + 32'd4);
    check("fetch_valid", 32'(fetch_valid), 32'(m_run));
    check("redirect_pending", 32'(redirect_pending), 32'(m_pend.size() != 0));
    check("misalign", 32'(misalign), 32'(m_mis));
  endtask

  task automatic model_reset();
    m_pc = 32'h0;
    m_pend.delete();
    m_run = 0;
    m_mis = 0;
  endtask

  // One clock of architectural behaviour, from the current inputs.
  task automatic model_cycle();
    logic [31:0] tgt;
    bit redir, adv;
    redir = jump_en || branch_taken;
    if (jump_en)
      tgt = (jump_base & 32'hF000_0000) | (32'(jump_index) * 4);
    else
      tgt = (branch_base + (branch_offset & ~32'h3)) & ~32'h3;
    if ((branch_taken && ((branch_offset % 4) != 0 || (branch_base % 4) != 0)) ||
        (jump_en && (jump_base % 4) != 0))
      m_mis = 1;
    adv = m_run && imem_ready && !stall;
    if (adv) begin
      if (m_pend.size() != 0) m_pc = m_pend.pop_front();
      else if (redir)         m_pc = tgt;
      else                    m_pc = m_pc + 32'd4;
    end else if (redir && m_pend.size() == 0) begin
      m_pend.push_back(tgt);
    end
    m_run = 1;
  endtask

  task automatic tick();
    model_cycle();
    @(negedge clk);
    check_all();
  endtask

  task automatic quiet();
    branch_taken = 0; jump_en = 0;
  endtask

  task automatic set_branch(input logic [31:0] base, input logic [31:0] off);
    branch_taken = 1; branch_base = base; branch_offset = off;
  endtask

  task automatic set_jump(input logic [31:0] base, input logic [25:0] idx);
    jump_en = 1; jump_base = base; jump_index = idx;
  endtask

  initial begin
    rst_n = 0; stall = 0; imem_ready = 1; branch_taken = 0; jump_en = 0;
    branch_base = 0; branch_offset = 0; jump_base = 0; jump_index = 0;
    model_reset();
    #12;
    check_all();
    @(negedge clk);
    rst_n = 1;
    check("boot_pc", pc, 32'h0);
    check("boot_fv", 32'(fetch_valid), 32'h0);

    // Sequential stepping after boot
    tick(); check("run_fv", 32'(fetch_valid), 32'h1);
    tick(); check("step4", pc, 32'h4);
    tick(); check("step8", pc, 32'h8);

    // Branches taken while advancing
    set_branch(32'h100, 32'hFFFF_FFF0); tick(); check("br_back", pc, 32'hF0);
    set_branch(32'h100, 32'h0000_0040); tick(); check("br_fwd", pc, 32'h140);

    // Jump beats a simultaneous branch
    set_jump(32'h4000_0010, 26'h123); tick(); check("jmp_wins", pc, 32'h4000_048C);
    quiet();

    // Redirects during a 3-cycle stall: first one is kept, jump dropped
    stall = 1;
    set_branch(32'h100, 32'h100); tick();
    check("stall_pend", 32'(redirect_pending), 32'h1);
    quiet(); set_jump(32'h0000_0000, 26'h3FF); tick();
    quiet(); tick();
    check("stall_hold", pc, 32'h4000_048C);
    stall = 0; tick();
    check("pend_apply", pc, 32'h200);
    check("pend_clear", 32'(redirect_pending), 32'h0);

    // Wrap through the top of the address space with memory wait states
    set_jump(32'hF000_0000, 26'h3FF_FFFF); tick(); quiet();
    check("top", pc, 32'hFFFF_FFFC);
    imem_ready = 0; tick(); tick();
    check("wait_hold", pc, 32'hFFFF_FFFC);
    imem_ready = 1; tick();
    check("wrap", pc, 32'h0);

    // Misaligned offset sets the sticky flag
    set_branch(32'h100, 32'h6); tick(); quiet();
    check("mis_set", 32'(misalign), 32'h1);
    check("mis_tgt", pc, 32'h104);
    tick(); tick();
    check("mis_sticky", 32'(misalign), 32'h1);

    // Asynchronous reset mid-cycle with a redirect pending
    stall = 1; set_branch(32'h300, 32'h10); tick(); quiet();
    check("pre_rst_pend", 32'(redirect_pending), 32'h1);
    #2 rst_n = 0;
    #1;
    check("arst_pc", pc, 32'h0);
    check("arst_pend", 32'(redirect_pending), 32'h0);
    check("arst_mis", 32'(misalign), 32'h0);
    check("arst_fv", 32'(fetch_valid), 32'h0);
    model_reset();
    stall = 0;
    @(negedge clk);
    rst_n = 1;
    check_all();

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      stall        = ($urandom_range(3) == 0);
      imem_ready   = ($urandom_range(3) != 0);
      branch_taken = ($urandom_range(4) == 0);
      jump_en      = ($urandom_range(5) == 0);
      branch_base  = $urandom & ~32'h3;
      branch_offset = {{14{$urandom_range(1) == 1}}, 16'($urandom), 2'b00};
      jump_base    = $urandom & ~32'h3;
      jump_index   = 26'($urandom);
      if ($urandom_range(40) == 0) branch_offset[1:0] = 2'($urandom_range(1, 3));
      if ($urandom_range(60) == 0) jump_base[1:0]     = 2'($urandom_range(1, 3));
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
